// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds selected reset domains low for a minimum width, then releases them one by one.
// Optional macro RST_SEQ_WDT_EN enables watchdog-triggered full resets via WDT_EXPIRE.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] SW_RST_MASK,
    input  logic                   WDT_EXPIRE,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   SW_RST_ACK,
    output logic                   SEQ_BUSY,
    output logic [1:0]             RST_CAUSE
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ASSERT  = 2'b01,
        S_RELEASE = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] pend_q, pend_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cause_q, cause_d;

    logic                   wdt_fire;
    logic [NUM_DOMAINS-1:0] lowest;

`ifdef RST_SEQ_WDT_EN
    assign wdt_fire = WDT_EXPIRE;
`else
    assign wdt_fire = WDT_EXPIRE & 1'b0;
`endif

    // Lowest still-pending domain: releases go in ascending index order.
    assign lowest = pend_q & (~pend_q + NUM_DOMAINS'(1));

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dom_d   = dom_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        cause_d = cause_q;

        case (state_q)
            S_IDLE: begin
                if (SW_RST_REQ) begin
                    ack_d = 1'b1;
                    if (|SW_RST_MASK) begin
                        state_d = S_ASSERT;
                        cnt_d   = '0;
                        pend_d  = SW_RST_MASK;
                        dom_d   = ~SW_RST_MASK;
                        busy_d  = 1'b1;
                        cause_d = CAUSE_SW;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    dom_d   = dom_q | lowest;
                    pend_d  = pend_q & ~lowest;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (pend_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    cnt_d  = '0;
                    dom_d  = dom_q | lowest;
                    pend_d = pend_q & ~lowest;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Watchdog overrides everything, including a same-cycle SW request.
        if (wdt_fire) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            pend_d  = '1;
            dom_d   = '0;
            ack_d   = 1'b0;
            busy_d  = 1'b1;
            cause_d = CAUSE_WDT;
        end
    end

    // Reset values describe a POR sequence already in its hold phase.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RST) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            pend_q  <= '1;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dom_q   <= dom_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign DOMAIN_RST_N = dom_q;
    assign SW_RST_ACK   = ack_q;
    assign SEQ_BUSY     = busy_q;
    assign RST_CAUSE    = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl at default parameters; follows RST_SEQ_WDT_EN if defined.
module tb_rst_seq_ctrl;

    localparam int HOLD    = 16;
    localparam int STAGGER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] sw_rst_mask = 3'b000;
    logic       wdt_expire = 1'b0;
    logic [2:0] domain_rst_n;
    logic       sw_rst_ack;
    logic       seq_busy;
    logic [1:0] rst_cause;

    int n_cmp  = 0;
    int n_fail = 0;

    rst_seq_ctrl #(
        .NUM_DOMAINS   (3),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAGGER)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .SW_RST_REQ  (sw_rst_req),
        .SW_RST_MASK (sw_rst_mask),
        .WDT_EXPIRE  (wdt_expire),
        .DOMAIN_RST_N(domain_rst_n),
        .SW_RST_ACK  (sw_rst_ack),
        .SEQ_BUSY    (seq_busy),
        .RST_CAUSE   (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] dom_e, input logic busy_e,
                             input logic ack_e, input logic [1:0] cause_e);
        check({tag, " dom"},   32'(domain_rst_n), 32'(dom_e));
        check({tag, " busy"},  32'(seq_busy),     32'(busy_e));
        check({tag, " ack"},   32'(sw_rst_ack),   32'(ack_e));
        check({tag, " cause"}, 32'(rst_cause),    32'(cause_e));
    endtask

    // Walks edges start..stop of a sequence. lead=1: request applied after edge k, d counts from k.
    // lead=0: POR, d counts from the edge at which RST was released. stop=0 runs to the busy drop.
    task automatic follow(input logic [2:0] mask, input logic [1:0] cause, input logic ack_exp,
                          input int lead, input int start, input int stop, input string tag);
        int         rel [3];
        int         j = 0;
        int         last = 0;
        int         fin;
        logic [2:0] dom_e;
        for (int i = 0; i < 3; i++) begin
            rel[i] = 0;
            if (mask[i]) begin
                rel[i] = lead + HOLD + STAGGER * j;
                last   = rel[i];
                j++;
            end
        end
        fin = (stop == 0) ? last + 1 : stop;
        for (int d = start; d <= fin; d++) begin
            tick();
            if (d == start) begin
                sw_rst_req  = 1'b0;
                sw_rst_mask = 3'b000;
                wdt_expire  = 1'b0;
            end
            for (int i = 0; i < 3; i++) dom_e[i] = !(mask[i] && d < rel[i]);
            check_all($sformatf("%s@%0d", tag, d), dom_e, d <= last, ack_exp && d == 1, cause);
        end
    endtask

    initial begin
        // Reset state while RST is held low.
        tick();
        check_all("rst_hold", 3'b000, 1'b1, 1'b0, 2'b00);
        tick();
        check_all("rst_hold2", 3'b000, 1'b1, 1'b0, 2'b00);
        rst = 1'b1;
        follow(3'b111, 2'b00, 1'b0, 0, 1, 0, "por");

        tick();
        check_all("idle", 3'b111, 1'b0, 1'b0, 2'b00);

        // SW sequence on domains 0 and 2.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b101;
        follow(3'b101, 2'b01, 1'b1, 1, 1, 0, "sw101");

        // SW request while busy is ignored.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b001;
        follow(3'b001, 2'b01, 1'b1, 1, 1, 5, "sw001");
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b011;
        follow(3'b001, 2'b01, 1'b1, 1, 6, 0, "sw_busy");

        // Zero mask in IDLE: ACK only.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b000;
        tick();
        sw_rst_req = 1'b0;
        check_all("mask0", 3'b111, 1'b0, 1'b1, 2'b01);
        tick();
        check_all("mask0_after", 3'b111, 1'b0, 1'b0, 2'b01);

        // WDT and SW in the same cycle.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b010;
        wdt_expire  = 1'b1;
`ifdef RST_SEQ_WDT_EN
        follow(3'b111, 2'b10, 1'b0, 1, 1, 0, "wdt_sw");
`else
        follow(3'b010, 2'b01, 1'b1, 1, 1, 0, "wdt_sw");
`endif

        // WDT during RELEASE, after domain 0 has come out of reset.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b111;
        follow(3'b111, 2'b01, 1'b1, 1, 1, 18, "sw111");
        wdt_expire = 1'b1;
`ifdef RST_SEQ_WDT_EN
        follow(3'b111, 2'b10, 1'b0, 1, 1, 0, "wdt_rel");
`else
        follow(3'b111, 2'b01, 1'b1, 1, 19, 0, "wdt_rel");
`endif

        // RST pulsed low mid-RELEASE acts asynchronously, then a POR runs.
        sw_rst_req  = 1'b1;
        sw_rst_mask = 3'b111;
        follow(3'b111, 2'b01, 1'b1, 1, 1, 22, "sw_pre_rst");
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 3'b000, 1'b1, 1'b0, 2'b00);
        tick();
        check_all("async_rst_hold", 3'b000, 1'b1, 1'b0, 2'b00);
        rst = 1'b1;
        follow(3'b111, 2'b00, 1'b0, 0, 1, 0, "por2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
